branch_predictor: RTL and testbench

- Fetch-side branch predictor paired with the EX-stage branch decision unit of the RV32IM pipeline.
- Predicts taken/not-taken and the target for the PC in IF.
- Trains a direct-mapped BTB with 2-bit saturating counters from the resolved branch outcome in EX.
- Raises mispredict/redirect to the PC mux and the pipeline flush logic.

---
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating
// counters, trained from the resolved branch in EX. It also raises the
// mispredict/redirect to the PC mux and keeps saturating branch statistics.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         if_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic                ex_stall,
  input  logic [31:0]         ex_pc,
  input  logic                ex_branch_taken,
  input  logic [31:0]         ex_target,
  input  logic                ex_pred_taken,
  input  logic [31:0]         ex_pred_target,
  output logic                mispredict,
  output logic [31:0]         redirect_pc,
  output logic [CNT_BITS-1:0] br_count,
  output logic [CNT_BITS-1:0] mispred_count
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  if_hit;
  logic                  ex_hit;
  logic                  upd;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  // Zero-latency lookup for the fetch PC; valid bits are cleared by reset,
  // so a prediction is never made while rst_n is low.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

  // Resolve: only a valid, unstalled conditional branch outside reset counts.
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd         = rst_n && ex_valid && ex_is_branch && !ex_stall;
  assign mispredict  = upd && ((ex_branch_taken != ex_pred_taken) ||
                               (ex_branch_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = !mispredict     ? 32'd0 :
                       ex_branch_taken ? ex_target : (ex_pc + 32'd4);

  // BTB training; not-taken misses never allocate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (ex_hit) begin
        if (ex_branch_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
          target_q[ex_idx] <= ex_target;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_branch_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  // Saturating branch and misprediction statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd && (br_count != {CNT_BITS{1'b1}}))
        br_count <= br_count + CNT_BITS'(1);
      if (mispredict && (mispred_count != {CNT_BITS{1'b1}}))
        mispred_count <= mispred_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run against a behavioural BTB model.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_stall;
  logic [31:0] ex_pc;
  logic        ex_branch_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_count, mispred_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: 16 entries, counter kept as an integer 0..3.
  bit          mv   [16];
  int unsigned mtag [16];
  logic [31:0] mtgt [16];
  int          mctr [16];
  int          mbr, mmis;

  bit          exp_pt, exp_mis;
  logic [31:0] exp_ptgt, exp_rpc;

  branch_predictor #(.INDEX_BITS(4), .CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0; mctr[i] = 1; mtag[i] = 0; mtgt[i] = 32'd0;
    end
    mbr = 0; mmis = 0;
  endtask

  task automatic model_eval();
    int unsigned idx, tag;
    bit u;
    idx = (if_pc / 4) % 16;
    tag = if_pc / 64;
    exp_pt   = rst_n && mv[idx] && (mtag[idx] == tag) && (mctr[idx] >= 2);
    exp_ptgt = exp_pt ? mtgt[idx] : if_pc + 32'd4;
    u = rst_n && ex_valid && ex_is_branch && !ex_stall;
    exp_mis = u && ((ex_branch_taken != ex_pred_taken) ||
                     (ex_branch_taken && (ex_pred_target != ex_target)));
    exp_rpc = !exp_mis ? 32'd0 : (ex_branch_taken ? ex_target : ex_pc + 32'd4);
  endtask

  task automatic model_train();
    int unsigned idx, tag;
    model_eval();
    if (!(rst_n && ex_valid && ex_is_branch && !ex_stall)) return;
    if (mbr < 65535) mbr++;
    if (exp_mis && mmis < 65535) mmis++;
    idx = (ex_pc / 4) % 16;
    tag = ex_pc / 64;
    if (mv[idx] && mtag[idx] == tag) begin
      if (ex_branch_taken) begin
        mctr[idx] = (mctr[idx] == 3) ? 3 : mctr[idx] + 1;
        mtgt[idx] = ex_target;
      end else begin
        mctr[idx] = (mctr[idx] == 0) ? 0 : mctr[idx] - 1;
      end
    end else if (ex_branch_taken) begin
      mv[idx] = 1'b1; mtag[idx] = tag; mtgt[idx] = ex_target; mctr[idx] = 2;
    end
  endtask

  task automatic drive(input logic [31:0] ipc, input logic v, input logic br,
                       input logic st, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt);
    if_pc = ipc; ex_valid = v; ex_is_branch = br; ex_stall = st; ex_pc = pc;
    ex_branch_taken = tk; ex_target = tgt; ex_pred_taken = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic idle(input logic [31:0] ipc);
    drive(ipc, 0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    #2;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
    n_cmp++; if (mispredict !== 1'b0 || redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_mispredict got %0b/%h want 0/0", mispredict, redirect_pc); end
    n_cmp++; if (br_count !== 16'd0 || mispred_count !== 16'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", br_count, mispred_count); end
    @(negedge clk); idle(32'h100); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin n_fail++; $display("FAIL post_reset_lookup got %0b/%h want 0/00000104", pred_taken, pred_target); end
  endtask

  task automatic test_train();
    // Allocate: lookup in the same cycle still sees the old (empty) entry.
    @(negedge clk); drive(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104); #1;
    n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin n_fail++; $display("FAIL alloc_redirect got %0b/%h want 1/00000080", mispredict, redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_lookup got %0b want 0", pred_taken); end
    @(posedge clk); model_train();
    @(negedge clk); idle(32'h100); #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin n_fail++; $display("FAIL after_alloc got %0b/%h want 1/00000080", pred_taken, pred_target); end
    n_cmp++; if (br_count !== 16'd1 || mispred_count !== 16'd1) begin n_fail++; $display("FAIL alloc_counts got %0d/%0d want 1/1", br_count, mispred_count); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80); #1;
      n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL strengthen_%0d got %0b want 0", i, mispredict); end
      @(posedge clk); model_train();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(32'h100, 1, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80); #1;
      n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin n_fail++; $display("FAIL weaken_%0d got %0b/%h want 1/00000104", i, mispredict, redirect_pc); end
      @(posedge clk); model_train();
    end
    @(negedge clk); idle(32'h100); #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin n_fail++; $display("FAIL weakened_lookup got %0b/%h want 0/00000104", pred_taken, pred_target); end
    n_cmp++; if (br_count !== 16'd5 || mispred_count !== 16'd3) begin n_fail++; $display("FAIL train_counts got %0d/%0d want 5/3", br_count, mispred_count); end
  endtask

  task automatic test_alias();
    @(negedge clk); drive(32'h0, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    @(posedge clk); model_train();
    @(negedge clk); drive(32'h0, 1, 1, 0, 32'h140, 1, 32'h200, 0, 32'h144);
    @(posedge clk); model_train();
    @(negedge clk); idle(32'h100); #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_evicted got %0b/%h want 0/00000104", pred_taken, pred_target); end
    idle(32'h140); #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin n_fail++; $display("FAIL alias_new got %0b/%h want 1/00000200", pred_taken, pred_target); end
  endtask

  task automatic test_correct_and_stall();
    int b0, m0;
    b0 = mbr; m0 = mmis;
    @(negedge clk); drive(32'h140, 1, 1, 0, 32'h140, 1, 32'h200, 1, 32'h200); #1;
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL correct_pred got %0b want 0", mispredict); end
    @(posedge clk); model_train();
    @(negedge clk); drive(32'h140, 1, 1, 1, 32'h140, 0, 32'h200, 1, 32'h200); #1;
    n_cmp++; if (br_count !== 16'(b0 + 1) || mispred_count !== 16'(m0)) begin n_fail++; $display("FAIL correct_counts got %0d/%0d want %0d/%0d", br_count, mispred_count, b0 + 1, m0); end
    n_cmp++; if (mispredict !== 1'b0 || redirect_pc !== 32'd0) begin n_fail++; $display("FAIL stall_mispredict got %0b/%h want 0/0", mispredict, redirect_pc); end
    @(posedge clk); model_train();
    @(negedge clk); idle(32'h140); #1;
    n_cmp++; if (br_count !== 16'(b0 + 1) || mispred_count !== 16'(m0)) begin n_fail++; $display("FAIL stall_counts got %0d/%0d want %0d/%0d", br_count, mispred_count, b0 + 1, m0); end
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin n_fail++; $display("FAIL stall_no_train got %0b/%h want 1/00000200", pred_taken, pred_target); end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h104;
    pool[3] = 32'h2000; pool[4] = 32'h13c; pool[5] = 32'hfffffffc;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      drive(pool[$urandom_range(0, 5)],
            logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 7) == 0),
            pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)),
            logic'($urandom_range(0, 2) != 0), pool[$urandom_range(0, 5)],
            logic'($urandom_range(0, 1)), pool[$urandom_range(0, 5)]);
      #1; model_eval();
      n_cmp++; if (pred_taken !== exp_pt || pred_target !== exp_ptgt) begin n_fail++; $display("FAIL rand_lookup c=%0d got %0b/%h want %0b/%h", c, pred_taken, pred_target, exp_pt, exp_ptgt); end
      n_cmp++; if (mispredict !== exp_mis || redirect_pc !== exp_rpc) begin n_fail++; $display("FAIL rand_resolve c=%0d got %0b/%h want %0b/%h", c, mispredict, redirect_pc, exp_mis, exp_rpc); end
      n_cmp++; if (br_count !== 16'(mbr) || mispred_count !== 16'(mmis)) begin n_fail++; $display("FAIL rand_counts c=%0d got %0d/%0d want %0d/%0d", c, br_count, mispred_count, mbr, mmis); end
      @(posedge clk); model_train();
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(32'h140, 1, 1, 0, 32'h140, 1, 32'h200, 1, 32'h200);
    @(posedge clk); model_train();
    @(negedge clk); drive(32'h140, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    rst_n = 1'b0; model_reset(); #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin n_fail++; $display("FAIL midreset_lookup got %0b/%h want 0/00000144", pred_taken, pred_target); end
    n_cmp++; if (mispredict !== 1'b0 || redirect_pc !== 32'd0) begin n_fail++; $display("FAIL midreset_resolve got %0b/%h want 0/0", mispredict, redirect_pc); end
    n_cmp++; if (br_count !== 16'd0 || mispred_count !== 16'd0) begin n_fail++; $display("FAIL midreset_counts got %0d/%0d want 0/0", br_count, mispred_count); end
    @(negedge clk); idle(32'h0); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle(32'h100 + 32'(i * 4)); #1;
      n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL post_midreset_%0d got %0b want 0", i, pred_taken); end
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_correct_and_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
